weight_tile_loader: RTL and testbench



---
 rtl/weight_tile_loader.sv | 160 ++++++++++++++++
 tb/tb_weight_tile_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_loader.sv
`timescale 1ns/1ps
// Purpose: assemble a serial weight stream into a shadow bank, then promote it to the active bank driving the PE array.
// Latency: last accepted beat at cycle t -> FULL at t+1 -> o_weights/o_swap_ack at t+2 at the earliest.
// Backpressure: o_data_out_en (pop request) is high only in FILL; a FULL tile waits for i_swap unless the active bank is empty.
module weight_tile_loader #(
  parameter int NUM_PE     = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(NUM_PE + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_reg_clear,
  input  logic                         i_load_start,
  input  logic [CNT_WIDTH-1:0]         i_load_size,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_data_valid,
  input  logic                         i_swap,
  output logic                         o_data_out_en,
  output logic [NUM_PE*DATA_WIDTH-1:0] o_weights,
  output logic                         o_weights_valid,
  output logic                         o_swap_ack,
  output logic                         o_busy,
  output logic                         o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [CNT_WIDTH-1:0]           cnt_q;
  logic [CNT_WIDTH-1:0]           cnt_inc;
  logic [CNT_WIDTH-1:0]           size_q;
  logic [NUM_PE*DATA_WIDTH-1:0]   shadow_q;
  logic [NUM_PE*DATA_WIDTH-1:0]   active_q;
  logic                           wvld_q;
  logic                           ack_q;
  logic                           err_q;

  logic                           size_ok;
  logic                           start_fill;
  logic                           accept_beat;
  logic                           promote;
  logic                           err_set;

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  assign size_ok = (i_load_size != '0) && (i_load_size <= CNT_WIDTH'(NUM_PE));

  // State register; clear shares reset values and outranks every other input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else if (i_reg_clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the beat that reaches the latched size closes the tile.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_fill) state_d = FILL;
      FILL:    if (accept_beat && (cnt_inc == size_q)) state_d = FULL;
      FULL:    if (promote) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state actions and protocol-error detection.
  always_comb begin
    start_fill  = 1'b0;
    accept_beat = 1'b0;
    promote     = 1'b0;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        start_fill = i_load_start && size_ok;
        // A beat here is the router overshooting its pop window.
        err_set    = (i_load_start && !size_ok) || i_data_valid;
      end
      FILL: begin
        accept_beat = i_data_valid;
        err_set     = i_load_start;
      end
      FULL: begin
        // An empty active bank takes the tile without waiting for a request.
        promote = i_swap || !wvld_q;
        err_set = i_load_start || i_data_valid;
      end
      default: ;
    endcase
  end

  // Shadow bank fill: zeroed at tile start so unwritten entries read 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      size_q   <= '0;
      shadow_q <= '0;
    end else if (i_reg_clear) begin
      cnt_q    <= '0;
      size_q   <= '0;
      shadow_q <= '0;
    end else if (start_fill) begin
      cnt_q    <= '0;
      size_q   <= i_load_size;
      shadow_q <= '0;
    end else if (accept_beat) begin
      cnt_q <= cnt_inc;
      for (int k = 0; k < NUM_PE; k++) begin
        if (cnt_q == CNT_WIDTH'(k)) begin
          shadow_q[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
        end
      end
    end
  end

  // Active bank promotion; the ack is registered alongside so it marks the update cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      active_q <= '0;
      wvld_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else if (i_reg_clear) begin
      active_q <= '0;
      wvld_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= promote;
      if (promote) begin
        active_q <= shadow_q;
        wvld_q   <= 1'b1;
      end
    end
  end

  // Sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (i_reg_clear) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign o_data_out_en   = (state_q == FILL);
  assign o_busy          = (state_q != IDLE);
  assign o_weights       = active_q;
  assign o_weights_valid = wvld_q;
  assign o_swap_ack      = ack_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_weight_tile_loader.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for weight_tile_loader.
// Latency: inputs change and outputs are sampled 1ns after each rising edge.
// Backpressure: pop request and promotion timing checked against hand-computed cycles.
module tb_weight_tile_loader;

  localparam int NUM_PE = 9;
  localparam int DW     = 8;
  localparam int CW     = 4;
  localparam int W      = NUM_PE * DW;

  localparam logic [W-1:0] TILE_A = 72'h090807060504030201;
  localparam logic [W-1:0] TILE_B = 72'h191817161514131211;
  localparam logic [W-1:0] TILE_P = 72'h0000000000DDCCBBAA;
  localparam logic [W-1:0] TILE_E = 72'h000000000000333231;
  localparam logic [W-1:0] TILE_R = 72'h494847464544434241;

  logic          clk;
  logic          rst;
  logic          reg_clear;
  logic          load_start;
  logic [CW-1:0] load_size;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          swap;
  logic          data_out_en;
  logic [W-1:0]  weights;
  logic          weights_valid;
  logic          swap_ack;
  logic          busy;
  logic          err;

  int tests = 0;
  int fails = 0;

  weight_tile_loader #(.NUM_PE(NUM_PE), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_reg_clear    (reg_clear),
    .i_load_start   (load_start),
    .i_load_size    (load_size),
    .i_data         (data),
    .i_data_valid   (data_valid),
    .i_swap         (swap),
    .o_data_out_en  (data_out_en),
    .o_weights      (weights),
    .o_weights_valid(weights_valid),
    .o_swap_ack     (swap_ack),
    .o_busy         (busy),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [CW-1:0] sz);
    load_start = 1'b1;
    load_size  = sz;
    tick();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    data       = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic clear();
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; reg_clear = 1'b0; load_start = 1'b0; load_size = '0;
    data = '0; data_valid = 1'b0; swap = 1'b0;
    #2;
    chkw("rst_weights", weights, '0);
    chk1("rst_wvld", weights_valid, 1'b0);
    chk1("rst_ack", swap_ack, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_pop", data_out_en, 1'b0);
    chk1("rst_err", err, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic load, auto-promote into the empty active bank.
    start(4'd9);
    chk1("basic_pop", data_out_en, 1'b1);
    chk1("basic_busy", busy, 1'b1);
    for (int i = 1; i <= 9; i++) beat(8'(i));
    chk1("basic_full_pop", data_out_en, 1'b0);
    chk1("basic_full_ack", swap_ack, 1'b0);
    chk1("basic_full_wvld", weights_valid, 1'b0);
    tick();
    chkw("basic_weights", weights, TILE_A);
    chk1("basic_ack", swap_ack, 1'b1);
    chk1("basic_wvld", weights_valid, 1'b1);
    chk1("basic_idle", busy, 1'b0);
    tick();
    chk1("basic_ack_once", swap_ack, 1'b0);
    chk1("basic_err", err, 1'b0);

    // Swap request in IDLE is ignored without error.
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk1("idle_swap_ack", swap_ack, 1'b0);
    chkw("idle_swap_weights", weights, TILE_A);
    chk1("idle_swap_err", err, 1'b0);

    // Ping-pong: tile B waits in FULL while tile A stays active.
    start(4'd9);
    for (int i = 1; i <= 9; i++) beat(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      tick();
      chkw("pp_hold_weights", weights, TILE_A);
      chk1("pp_hold_busy", busy, 1'b1);
      chk1("pp_hold_ack", swap_ack, 1'b0);
    end
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chkw("pp_weights", weights, TILE_B);
    chk1("pp_ack", swap_ack, 1'b1);
    chk1("pp_idle", busy, 1'b0);
    tick();

    // Partial tile: upper entries come back zero.
    start(4'd4);
    beat(8'hAA); beat(8'hBB); beat(8'hCC); beat(8'hDD);
    chk1("part_full", data_out_en, 1'b0);
    chkw("part_hold", weights, TILE_B);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chkw("part_weights", weights, TILE_P);
    chk1("part_ack", swap_ack, 1'b1);
    tick();

    // Bubbles: valid every other cycle, junk data on idle cycles; swap held throughout.
    swap = 1'b1;
    start(4'd9);
    for (int i = 1; i <= 9; i++) begin
      beat(8'(i));
      if (i < 9) begin
        data = 8'hEE;
        tick();
      end
    end
    chk1("bub_ack_early", swap_ack, 1'b0);
    chkw("bub_hold", weights, TILE_P);
    tick();
    swap = 1'b0;
    chkw("bub_weights", weights, TILE_A);
    chk1("bub_ack", swap_ack, 1'b1);
    chk1("bub_err", err, 1'b0);
    tick();

    // Clear beats a same-cycle start and empties everything.
    reg_clear = 1'b1; load_start = 1'b1; load_size = 4'd9;
    tick();
    reg_clear = 1'b0; load_start = 1'b0;
    chkw("clr_weights", weights, '0);
    chk1("clr_wvld", weights_valid, 1'b0);
    chk1("clr_busy", busy, 1'b0);

    // Error (a): illegal sizes.
    start(4'd0);
    chk1("err_size0", err, 1'b1);
    chk1("err_size0_busy", busy, 1'b0);
    clear();
    chk1("err_size0_clr", err, 1'b0);
    start(4'd10);
    chk1("err_size10", err, 1'b1);
    chk1("err_size10_busy", busy, 1'b0);
    clear();

    // Error (b): stray beat in IDLE.
    beat(8'h55);
    chk1("err_stray", err, 1'b1);
    clear();
    chk1("err_stray_clr", err, 1'b0);

    // Error (c): start during FILL must not disturb the tile in progress.
    start(4'd3);
    load_start = 1'b1; load_size = 4'd9;
    beat(8'h31);
    load_start = 1'b0;
    chk1("err_mid_start", err, 1'b1);
    chk1("err_mid_busy", busy, 1'b1);
    beat(8'h32); beat(8'h33);
    chk1("err_mid_noack", swap_ack, 1'b0);
    tick();
    chkw("err_mid_weights", weights, TILE_E);
    chk1("err_mid_ack", swap_ack, 1'b1);
    chk1("err_sticky", err, 1'b1);
    clear();
    chk1("err_clr", err, 1'b0);
    chkw("err_clr_weights", weights, '0);

    // Reset mid-FILL with a populated active bank.
    start(4'd9);
    for (int i = 1; i <= 9; i++) beat(8'(i));
    tick();
    chkw("rmf_pre", weights, TILE_A);
    start(4'd9);
    for (int i = 1; i <= 5; i++) beat(8'(i));
    beat(8'h77);
    chk1("rmf_err_pre", err, 1'b0);
    data_valid = 1'b0;
    rst = 1'b1;
    #2;
    chkw("rmf_weights", weights, '0);
    chk1("rmf_wvld", weights_valid, 1'b0);
    chk1("rmf_busy", busy, 1'b0);
    chk1("rmf_pop", data_out_en, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    start(4'd9);
    for (int i = 1; i <= 9; i++) beat(8'(8'h40 + i));
    tick();
    chkw("rmf_reload", weights, TILE_R);
    chk1("rmf_ack", swap_ack, 1'b1);
    chk1("rmf_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
